// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response handshake plus data-memory bus of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        memread;
  logic        memwrite;
  logic [12:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  // LSU side: accepts requests, drives the memory strobes, consumes read_data
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, read_data,
    output req_ready, resp_valid, resp_rdata, resp_err, memread, memwrite, address, write_data
  );

  // Pipeline/memory side: issues requests, supplies read_data
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err, memread, memwrite, address, write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a 32-bit word memory, with
// alignment/range checking, sign extension and read-modify-write sub-word stores.
module load_store_unit (
  input  logic clk,
  input  logic rst_n,
  load_store_unit_if.slave bus
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;

  state_t      state, state_next;
  logic [1:0]  size;
  logic        is_signed;
  logic [1:0]  lane;
  logic [31:0] wdata;
  logic [12:0] address_r;
  logic [31:0] write_data_r;
  logic [31:0] rdata_r;
  logic        err_r;

  logic        accept;
  logic        req_err;
  logic [4:0]  shift;
  logic [31:0] shifted;
  logic [31:0] load_value;
  logic [31:0] lane_mask;
  logic [31:0] insert;
  logic [31:0] merged;

  assign bus.req_ready  = rst_n && (state == IDLE);
  assign bus.memread    = rst_n && ((state == RD) || (state == RMW_RD));
  assign bus.memwrite   = rst_n && ((state == WR) || (state == RMW_WR));
  assign bus.resp_valid = rst_n && (state == RESP);
  assign bus.resp_rdata = rdata_r;
  assign bus.resp_err   = err_r;
  assign bus.address    = address_r;
  assign bus.write_data = write_data_r;

  assign accept = bus.req_valid && bus.req_ready;
  assign shift  = {lane, 3'b000};

  // Request legality: reserved size, misalignment, or outside the 32 KiB window
  always_comb begin
    req_err = 1'b0;
    if (bus.req_size == 2'b11)                                  req_err = 1'b1;
    if ((bus.req_size == SIZE_HALF) && bus.req_addr[0])         req_err = 1'b1;
    if ((bus.req_size == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00)) req_err = 1'b1;
    if (bus.req_addr[31:15] != '0)                              req_err = 1'b1;
  end

  // Lane extraction with optional sign extension for loads
  always_comb begin
    shifted    = bus.read_data >> shift;
    load_value = shifted;
    case (size)
      SIZE_BYTE: load_value = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_value = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default:   load_value = shifted;
    endcase
  end

  // Sub-word store merge: replace only the target lanes of the fetched word
  always_comb begin
    lane_mask = '1;
    insert    = wdata;
    case (size)
      SIZE_BYTE: begin
        lane_mask = 32'h0000_00ff << shift;
        insert    = {24'h0, wdata[7:0]} << shift;
      end
      SIZE_HALF: begin
        lane_mask = 32'h0000_ffff << shift;
        insert    = {16'h0, wdata[15:0]} << shift;
      end
      default: begin
        lane_mask = '1;
        insert    = wdata;
      end
    endcase
    merged = (bus.read_data & ~lane_mask) | insert;
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                          state_next = RESP;
          else if (!bus.req_write)              state_next = RD;
          else if (bus.req_size == SIZE_WORD)   state_next = WR;
          else                                  state_next = RMW_RD;
        end
      end
      RD:      state_next = RESP;
      WR:      state_next = RESP;
      RMW_RD:  state_next = RMW_WR;
      RMW_WR:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Request capture, load result and store word registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      size         <= SIZE_BYTE;
      is_signed    <= 1'b0;
      lane         <= '0;
      wdata        <= '0;
      address_r    <= '0;
      write_data_r <= '0;
      rdata_r      <= '0;
      err_r        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            size         <= bus.req_size;
            is_signed    <= bus.req_signed;
            lane         <= bus.req_addr[1:0];
            wdata        <= bus.req_wdata;
            address_r    <= bus.req_addr[14:2];
            write_data_r <= bus.req_wdata;
            rdata_r      <= '0;
            err_r        <= req_err;
          end
        end
        RD:      rdata_r      <= load_value;
        // The write_data register doubles as the captured word for the merge
        RMW_RD:  write_data_r <= merged;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port req_valid, input, 1 bit: pipeline access request.
REQ-004 SHALL have port req_ready, output, 1 bit: unit can accept a request.
REQ-005 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 reserved.
REQ-007 SHALL have port req_signed, input, 1 bit: sign-extend sub-word loads.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32 bits: load result; 0 for stores and errors.
REQ-012 SHALL have port resp_err, output, 1 bit: access rejected; valid with resp_valid.
REQ-013 SHALL have port memread, output, 1 bit: data memory read strobe.
REQ-014 SHALL have port memwrite, output, 1 bit: data memory write strobe; memory writes on the rising clk edge.
REQ-015 SHALL have port address, output, 13 bits: memory word index.
REQ-016 SHALL have port write_data, output, 32 bits: memory write word.
REQ-017 SHALL have port read_data, input, 32 bits: memory word, combinational while memread=1.

Function
REQ-018 SHALL implement FSM states IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
REQ-019 SHALL drive req_ready=1 only in IDLE with rst_n=1, and SHALL accept a request on a rising edge where req_valid=1 and req_ready=1.
REQ-020 SHALL register req_* fields at acceptance and ignore req_* inputs outside IDLE.
REQ-021 SHALL map the memory word to address = req_addr[14:2], using little-endian byte lanes: lane k = bits 8k+7:8k, at req_addr[1:0]=k.
REQ-022 SHALL flag an error when req_size=11, req_size=01 with addr[0]=1, req_size=10 with addr[1:0]!=0, or req_addr[31:15]!=0.
REQ-023 SHALL transition IDLE->RESP on an erroneous request, with resp_err=1, resp_rdata=0, and no memread or memwrite pulse.
REQ-024 SHALL handle a load as IDLE->RD->RESP: memread=1 in RD, the selected lanes extracted from read_data and registered at the end of RD, and zero-extension or sign-extension (req_signed=1) to 32 bits.
REQ-025 SHALL handle a word store as IDLE->WR->RESP, with memwrite=1 and write_data=req_wdata in WR.
REQ-026 SHALL handle a byte or half store as IDLE->RMW_RD->RMW_WR->RESP: memread=1 in RMW_RD with read_data captured; memwrite=1 in RMW_WR with write_data = captured word with only the target lanes replaced by req_wdata[7:0] or req_wdata[15:0].
REQ-027 SHALL hold address stable through every access state of a request.
REQ-028 SHALL keep memread and memwrite mutually exclusive and never asserted in IDLE or RESP.
REQ-029 SHALL pulse resp_valid for exactly one cycle in RESP, then return to IDLE; resp_valid has no backpressure.
REQ-030 SHALL meet these latencies (cycles from the accept edge to the resp_valid cycle): error 1, load 2, word store 2, sub-word store 3.
REQ-031 SHALL allow back-to-back requests, so the next accept can occur in the first IDLE cycle after RESP.

Reset
REQ-032 SHALL, on a rising edge with rst_n=0, enter IDLE and clear resp_valid, resp_err, resp_rdata, address, write_data, and the captured registers.
REQ-033 SHALL force memread=0, memwrite=0, and req_ready=0 combinationally whenever rst_n=0.
REQ-034 SHALL, on reset during any access state, abandon the request with no response, no write pulse, and no memory write on that edge.

Verification
REQ-035 SHALL pass a word store then load: store addr 0x10, data 0x12345678 -> memwrite pulse with address=4; then load word from 0x10 -> resp_rdata=0x12345678 two cycles after accept, resp_err=0.
REQ-036 SHALL pass a byte store merge: memory word 4 = 0xAABBCCDD; store byte 0x11 at 0x12 -> after 3 cycles word 4 = 0xAA11CCDD, with memread then memwrite on consecutive cycles.
REQ-037 SHALL pass sign extension: word 4 = 0x80FF7F01; signed half load 0x12 -> 0xFFFF80FF; unsigned byte load 0x11 -> 0x0000007F; signed byte 0x13 -> 0xFFFFFF80.
REQ-038 SHALL pass error handling: word load at 0x13, half store at 0x11, size=11, or addr 0x00008000 -> resp_err=1 and resp_rdata=0 one cycle after accept, with no memory strobes.
REQ-039 SHALL pass reset mid-operation: rst_n=0 during RMW_RD of a byte store -> no memwrite, no resp_valid, memory unchanged, and req_ready=1 on the first cycle with rst_n=1.
REQ-040 SHALL pass back-to-back traffic: req_valid held high with 4 alternating loads and stores -> each request is accepted in the IDLE cycle after the previous RESP, with correct data.
